activation_skew_buffer: RTL
===========================

Name: activation_skew_buffer

Overview:
- Upstream feeder for the 16x16 matrix-multiply unit.
- Accepts one activation row per cycle (16 lanes x 8-bit signed) over a valid/ready handshake.
- Skews lane i by i cycles to form the diagonal wavefront the systolic array needs, and drives its ain bus.
- After the last row of a batch, pushes zeros until the final element has left lane 15, then pulses done.

Parameters:
- LANES, 16, number of array rows / activation lanes.
- DATA_W, 8, activation width, two's complement.

Ports:
- clk, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_data / in_last valid this cycle.
- in_ready, output, 1, block can accept a row this cycle.
- in_last, input, 1, marks final row of a batch.
- in_data, input, LANES*DATA_W, lane k at bits [k*DATA_W +: DATA_W].
- ain, output, LANES*DATA_W, skewed activations to the MMU ain, same lane packing.
- ain_valid, output, 1, at least one lane of ain carries accepted (non-filler) data.
- busy, output, 1, state is FEED or FLUSH.
- done, output, 1, one-cycle pulse when the batch has fully drained.

Behaviour:
- Reset (asynchronous, any time, including mid-batch): all delay registers 0, ain = 0, ain_valid = 0, in_ready = 0 while reset_n is low then 1, busy = 0, done = 0, state IDLE, flush counter 0. Partial batch is discarded.
- Accept: a beat is accepted when in_valid && in_ready at a rising edge.
- Delay lines:
  - Lane k is a register chain of depth k+1 that advances every cycle, unconditionally.
  - Input to the chain is in_data lane k when a beat is accepted, otherwise 0 (bubble filler).
  - Lane k therefore shows row r's element exactly k+1 cycles after acceptance; lane 0 latency 1, lane 15 latency 16.
  - Data passes through bit-exact; no arithmetic.
- Valid tracking: shift register vld[0..LANES-1], vld[0] <= accept, vld[j] <= vld[j-1]; ain_valid = OR of all vld bits (registered output).
- State machine:
  - IDLE: in_ready = 1, busy = 0. Accept without in_last -> FEED. Accept with in_last -> FLUSH (single-row batch).
  - FEED: in_ready = 1, busy = 1. Accept with in_last -> FLUSH, flush counter loaded with LANES-1. Cycles with in_valid = 0 insert zero rows; stay in FEED.
  - FLUSH: in_ready = 0, busy = 1; in_valid and in_last are ignored. Zeros are shifted in each cycle and the counter decrements. When counter = 0 -> IDLE, done = 1 for that cycle.
- Drain timing: done asserts in the same cycle lane LANES-1 presents the last row's element, i.e. LANES cycles after the in_last beat. ain_valid falls on the following cycle.
- in_last with in_valid = 0 has no effect.
- A back-to-back batch is allowed from the cycle after done. in_ready is 1 in IDLE, so the next row is accepted in the cycle after done.

Optional Feature:
- Macro: ASB_ROW_COUNT_EN.
- Defined:
  - Adds output row_count [15:0] = number of beats accepted in the current batch, saturating at 16'hFFFF.
  - Holds its value after done; cleared to 1 on the first accept of the next batch; 0 at reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package asb_pkg holds LANES/DATA_W defaults, state encoding (IDLE=2'd0, FEED=2'd1, FLUSH=2'd2), and the flush counter width ($clog2(LANES)).
- Sub-module skew_delay_line (parameters DEPTH, WIDTH; ports clk, reset_n, d, q), instantiated once per lane via generate with DEPTH = k+1.

Test Plan:
- Reset mid-FEED after 5 rows -> ain = 0, ain_valid = 0, busy = 0 immediately; in_ready = 1 after release; next batch unaffected.
- Single row {lane k = k+1}, in_last = 1 in IDLE -> lane k of ain = k+1 at exactly cycle k+1 after accept, 0 otherwise; done at cycle 16; in_ready = 0 during cycles 1-16.
- 16 rows, row r lane k = -(r+1) (8'hFF down to 8'hF0), continuous valid, in_last on row 15 -> lane k shows rows 0..15 in order starting at cycle k+1; done 16 cycles after the last accept; ain_valid high from cycle 1 through the done cycle.
- Bubble insertion: rows A, gap of 2 cycles, row B (in_last) -> lane k carries A, 0, 0, B at cycles k+1..k+4; ain_valid remains 1 across the bubble.
- in_valid = 1 held throughout FLUSH with changing data -> no extra acceptances; ain after the last row is all zeros; done fires once.
- ASB_ROW_COUNT_EN defined: batch of 3 rows -> row_count = 1, 2, 3, then holds 3 after done; the next batch's first accept sets it to 1.

Source files
------------

// File: rtl/activation_skew_buffer_pkg.sv
// Shared constants and state encoding for the activation skew buffer.
package asb_pkg;

    localparam int DEF_LANES  = 16;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic int flush_cnt_w(input int lanes);
        return $clog2(lanes);
    endfunction

    localparam int FLUSH_CNT_W = flush_cnt_w(DEF_LANES);

endpackage

// File: rtl/activation_skew_buffer_skew_delay_line.sv
// Fixed-depth register chain that shifts every cycle; one instance per lane
// gives that lane its diagonal skew.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/activation_skew_buffer.sv
// Skews incoming activation rows into a diagonal wavefront for the systolic MMU.
// Optional ASB_ROW_COUNT_EN adds a saturating per-batch row_count output.
module activation_skew_buffer
    import asb_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic [LANES*DATA_W-1:0] ain,
    output logic                    ain_valid,
    output logic                    busy,
    output logic                    done
`ifdef ASB_ROW_COUNT_EN
    ,
    output logic [15:0]             row_count
`endif
);

    localparam int CNT_W = flush_cnt_w(LANES);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [LANES-1:0] vld;
    logic             accept;

    assign in_ready  = reset_n && (state != FLUSH);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign ain_valid = |vld;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            vld   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            vld   <= {vld[LANES-2:0], accept};
        end
    end

    // The flush counter spans the LANES cycles the last row needs to reach lane LANES-1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done       = 1'b0;
        case (state)
            IDLE, FEED: begin
                if (accept) begin
                    if (in_last) begin
                        state_next = FLUSH;
                        cnt_next   = CNT_W'(LANES - 1);
                    end else begin
                        state_next = FEED;
                    end
                end
            end
            FLUSH: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_W-1:0] lane_in;

        assign lane_in = accept ? in_data[k*DATA_W +: DATA_W] : '0;

        skew_delay_line #(
            .DEPTH (k + 1),
            .WIDTH (DATA_W)
        ) u_delay (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (lane_in),
            .q       (ain[k*DATA_W +: DATA_W])
        );
    end

`ifdef ASB_ROW_COUNT_EN
    // An accept seen in IDLE opens a new batch, so the count restarts at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_count <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                row_count <= 16'd1;
            end else if (row_count != 16'hFFFF) begin
                row_count <= row_count + 16'd1;
            end
        end
    end
`endif

endmodule
